mic1_reg_file: RTL and testbench
================================

# mic1_reg_file

Register file and memory-port stage of the MIC-1 datapath, directly upstream of the ALU. It holds the ten architectural registers (MAR, MDR, PC, MBR, SP, LV, CPP, TOS, OPC, H), drives H onto the A bus and a selected register onto the B bus, and writes back the shifter's C-bus result. It also owns the read, write and fetch handshakes to memory, and stalls the control store when a microinstruction would consume MDR or MBR before its data has returned.

## Interface
Parameters:
- `PC_RST`, 32'h0000_0000, PC reset value
- `SP_RST`, 32'h0000_8000, SP reset value
- `LV_RST`, 32'h0000_8000, LV reset value
- `CPP_RST`, 32'h0000_4000, CPP reset value

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: datapath clock
- `rst_n` in 1: asynchronous active-low reset
- `b_sel` in 4: B-bus source select
- `c_en` in 9: C-bus write enables; bits 8..0 = H, OPC, TOS, CPP, LV, SP, PC, MDR, MAR
- `c_bus` in 32: shifter result
- `rd`, `wr`, `fetch` in 1 each: microinstruction memory bits
- `a_bus` out 32: H
- `b_bus` out 32: selected source
- `stall` out 1: microinstruction must be held and re-presented
- `mem_addr` out 32: MAR<<2 (byte address)
- `mem_wdata` out 32: MDR
- `mem_rd_req` out 1: data read request
- `mem_wr_req` out 1: data write request
- `mem_rdata` in 32: read data
- `mem_rvalid` in 1: read data valid
- `ifu_addr` out 32: PC
- `ifu_req` out 1: byte fetch request
- `ifu_rdata` in 8: fetched byte
- `ifu_rvalid` in 1: fetch data valid

## Operation
- B-bus select:
  - 0: MDR
  - 1: PC
  - 2: MBR sign-extended to 32 bits
  - 3: MBR zero-extended to 32 bits
  - 4: SP
  - 5: LV
  - 6: CPP
  - 7: TOS
  - 8: OPC
  - 9–15: 32'h0
- Combinational paths: `a_bus` = H at all times; `b_bus` is purely combinational from `b_sel`.
- Accept condition: a microinstruction is accepted on a rising edge where `stall`=0. On acceptance:
  - every register with its `c_en` bit set loads `c_bus`;
  - `rd`, `wr` and `fetch` are latched for issue.
- Memory issue: requests issue in the cycle after acceptance.
  - `mem_addr`, `mem_wdata` and `ifu_addr` reflect register values after that edge, so a microinstruction may load MAR and read in the same word.
  - `mem_rd_req`, `mem_wr_req` and `ifu_req` are one-cycle pulses.
  - Writes are fire-and-forget.
  - `rd` and `wr` in the same microinstruction: both pulses are issued; memory performs the read first.
- Pending flags: `rd_pend` sets on `mem_rd_req` and clears on `mem_rvalid`. `ft_pend` sets on `ifu_req` and clears on `ifu_rvalid`.
- Return data loads:
  - `mem_rvalid` loads MDR from `mem_rdata`.
  - `ifu_rvalid` loads MBR from `ifu_rdata`.
  - A `rvalid` without a pending request is ignored.
- Stall conditions: `stall` = any of the following while the corresponding request is pending or issuing this cycle:
  - `rd` asserted while a read is pending;
  - `b_sel`=0 while a read is pending;
  - `c_en[MDR]` set while a read is pending;
  - `fetch` asserted while a fetch is pending;
  - `b_sel`=2 or 3 while a fetch is pending.
- Collision: if `mem_rvalid` and an accepted `c_en[MDR]` write coincide, memory data wins. This case is unreachable when stall works.

## Timing
- Reset (asynchronous on `rst_n` low):
  - PC, SP, LV and CPP take their parameter values; all other registers are 0.
  - Pending flags are cleared; all request outputs are 0.
  - `stall` is 0.
  - Reset mid-transaction drops the outstanding request, and late `rvalid` is ignored.
- Register write latency: 1 edge.
- Read/fetch:
  - Request issues at cycle k+1 for a microinstruction accepted at edge k.
  - Data is usable on the B bus the cycle after `rvalid`.
  - With 1-cycle memory, data is usable at k+3.
- `stall` is combinational and never gated by `clk`.

## Structure
- Package `mic1_pkg`:
  - `b_sel_e` enum;
  - `C_H`..`C_MAR` bit-index constants;
  - `WORD_W`=32.
- Sub-module `mic1_mem_port`: pending flags, request pulses and stall generation. The register array and bus mux stay in the top level.

## Test plan
- **Reset:** apply reset → SP=32'h8000, PC=0, `b_sel`=4 gives `b_bus`=32'h8000, no requests.
- **Write/read-back:** `c_en`=9'h100 with `c_bus`=32'hDEAD_BEEF → `a_bus`=32'hDEAD_BEEF next cycle; `b_sel`=9 → 0.
- **Read hazard:**
  - Stimulus: MAR←5 with `rd`; next microinstruction `b_sel`=0.
  - Response: `mem_addr`=32'h14 with a one-cycle `mem_rd_req`; `stall`=1 until `mem_rvalid` returns `mem_rdata`=32'h1234; then `b_bus`=32'h1234.
- **Fetch sign extension:**
  - Stimulus: `fetch` with PC=3; `ifu_rdata`=8'h9C.
  - Response: `b_sel`=2 gives 32'hFFFF_FF9C; `b_sel`=3 gives 32'h0000_009C.
- **Write:**
  - Stimulus: MAR←2, MDR←7, `wr` in one microinstruction.
  - Response: next cycle `mem_wr_req`=1, `mem_addr`=8, `mem_wdata`=7; no stall.
- **Mid-read reset:** reset asserted with a read pending → pending flag clears; a later `mem_rvalid` leaves MDR=0.

Source files
------------

// File: rtl/mic1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mic1_pkg
// Description : Shared types and constants for the MIC-1 register file stage:
//               word width, C-bus enable bit positions, B-bus source encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mic1_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_CREGS = 9;

  // Bit positions inside the 9-bit C-bus enable field
  localparam int C_MAR = 0;
  localparam int C_MDR = 1;
  localparam int C_PC  = 2;
  localparam int C_SP  = 3;
  localparam int C_LV  = 4;
  localparam int C_CPP = 5;
  localparam int C_TOS = 6;
  localparam int C_OPC = 7;
  localparam int C_H   = 8;

  // B-bus source encoding; codes 9..15 select a zero word
  typedef enum logic [3:0] {
    B_MDR   = 4'd0,
    B_PC    = 4'd1,
    B_MBR_S = 4'd2,
    B_MBR_U = 4'd3,
    B_SP    = 4'd4,
    B_LV    = 4'd5,
    B_CPP   = 4'd6,
    B_TOS   = 4'd7,
    B_OPC   = 4'd8
  } b_sel_e;

  // Sign-extend a fetched byte to a full datapath word
  function automatic logic [WORD_W-1:0] sext8(input logic [7:0] b);
    return {{(WORD_W-8){b[7]}}, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mic1_reg_file_if.sv
`default_nettype none
// ============================================================================
// Module      : mic1_reg_file_if
// Description : Memory-side bundle of the register file stage: data port
//               (word read/write) and instruction-fetch byte port.
// Revision    : 1.0 - initial release
// ============================================================================
interface mic1_reg_file_if;
  import mic1_pkg::*;

  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic [WORD_W-1:0] ifu_addr;
  logic              ifu_req;
  logic [7:0]        ifu_rdata;
  logic              ifu_rvalid;

  // Datapath side issues requests and consumes returned data
  modport master (
    output mem_addr, mem_wdata, mem_rd_req, mem_wr_req, ifu_addr, ifu_req,
    input  mem_rdata, mem_rvalid, ifu_rdata, ifu_rvalid
  );

  // Memory side answers requests
  modport slave (
    input  mem_addr, mem_wdata, mem_rd_req, mem_wr_req, ifu_addr, ifu_req,
    output mem_rdata, mem_rvalid, ifu_rdata, ifu_rvalid
  );

endinterface
`default_nettype wire

// File: rtl/mic1_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : mic1_mem_port
// Description : Memory handshake control for the MIC-1 register file:
//               request pulses, outstanding read/fetch tracking and the
//               combinational stall towards the control store.
// Revision    : 1.0 - initial release
// ============================================================================
module mic1_mem_port
  import mic1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] b_sel,
  input  logic       mdr_wr_en,
  input  logic       rd,
  input  logic       wr,
  input  logic       fetch,
  input  logic       mem_rvalid,
  input  logic       ifu_rvalid,
  output logic       stall,
  output logic       accept,
  output logic       mem_rd_req,
  output logic       mem_wr_req,
  output logic       ifu_req,
  output logic       mdr_load,
  output logic       mbr_load
);

  logic rd_pend;
  logic ft_pend;
  logic rd_busy;
  logic ft_busy;
  logic uses_mdr;
  logic uses_mbr;

  // A read/fetch counts as in flight from its issue cycle until the data returns
  always_comb begin
    rd_busy  = rd_pend | mem_rd_req;
    ft_busy  = ft_pend | ifu_req;
    uses_mdr = rd | (b_sel == B_MDR) | mdr_wr_en;
    uses_mbr = fetch | (b_sel == B_MBR_S) | (b_sel == B_MBR_U);
    stall    = (rd_busy & uses_mdr) | (ft_busy & uses_mbr);
    accept   = ~stall;
    // Returned data is only taken when a request is actually outstanding
    mdr_load = mem_rvalid & rd_pend;
    mbr_load = ifu_rvalid & ft_pend;
  end

  // Request pulses: one cycle, issued the cycle after the word is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_req <= 1'b0;
      mem_wr_req <= 1'b0;
      ifu_req    <= 1'b0;
    end else begin
      mem_rd_req <= accept & rd;
      mem_wr_req <= accept & wr;
      ifu_req    <= accept & fetch;
    end
  end

  // Pending flags: set by the issued pulse, cleared by the matching rvalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      ft_pend <= 1'b0;
    end else begin
      rd_pend <= mem_rd_req | (rd_pend & ~mem_rvalid);
      ft_pend <= ifu_req | (ft_pend & ~ifu_rvalid);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mic1_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : mic1_reg_file
// Description : MIC-1 register file and memory-port stage. Holds MAR, MDR,
//               PC, MBR, SP, LV, CPP, TOS, OPC and H; drives the A and B
//               buses into the ALU; writes back the C bus; owns the memory
//               read/write/fetch handshakes and the control-store stall.
// Revision    : 1.0 - initial release
// ============================================================================
module mic1_reg_file
  import mic1_pkg::*;
#(
  parameter logic [WORD_W-1:0] PC_RST  = 32'h0000_0000,
  parameter logic [WORD_W-1:0] SP_RST  = 32'h0000_8000,
  parameter logic [WORD_W-1:0] LV_RST  = 32'h0000_8000,
  parameter logic [WORD_W-1:0] CPP_RST = 32'h0000_4000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           b_sel,
  input  logic [NUM_CREGS-1:0] c_en,
  input  logic [WORD_W-1:0]    c_bus,
  input  logic                 rd,
  input  logic                 wr,
  input  logic                 fetch,
  output logic [WORD_W-1:0]    a_bus,
  output logic [WORD_W-1:0]    b_bus,
  output logic                 stall,
  mic1_reg_file_if.master      mem
);

  logic [NUM_CREGS-1:0][WORD_W-1:0] regs;
  logic [7:0]                       mbr;
  logic                             accept;
  logic                             mdr_load;
  logic                             mbr_load;

  mic1_mem_port u_mem_port (
    .clk        (clk),
    .rst_n      (rst_n),
    .b_sel      (b_sel),
    .mdr_wr_en  (c_en[C_MDR]),
    .rd         (rd),
    .wr         (wr),
    .fetch      (fetch),
    .mem_rvalid (mem.mem_rvalid),
    .ifu_rvalid (mem.ifu_rvalid),
    .stall      (stall),
    .accept     (accept),
    .mem_rd_req (mem.mem_rd_req),
    .mem_wr_req (mem.mem_wr_req),
    .ifu_req    (mem.ifu_req),
    .mdr_load   (mdr_load),
    .mbr_load   (mbr_load)
  );

  // One register per C-bus enable bit; PC/SP/LV/CPP reset to their parameters
  for (genvar i = 0; i < NUM_CREGS; i++) begin : g_creg
    localparam logic [WORD_W-1:0] RST_VAL = (i == C_PC)  ? PC_RST  :
                                            (i == C_SP)  ? SP_RST  :
                                            (i == C_LV)  ? LV_RST  :
                                            (i == C_CPP) ? CPP_RST : '0;
    logic [WORD_W-1:0] q;

    if (i == C_MDR) begin : g_mdr
      // MDR: returning memory data takes priority over a C-bus write
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          q <= RST_VAL;
        else if (mdr_load)
          q <= mem.mem_rdata;
        else if (accept && c_en[i])
          q <= c_bus;
      end
    end else begin : g_plain
      // Ordinary register: loads C bus when its enable is set on acceptance
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          q <= RST_VAL;
        else if (accept && c_en[i])
          q <= c_bus;
      end
    end

    assign regs[i] = q;
  end

  // MBR is only written by the fetch port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mbr <= 8'h00;
    else if (mbr_load)
      mbr <= mem.ifu_rdata;
  end

  // B-bus source multiplexer; unused codes read as zero
  always_comb begin
    b_bus = '0;
    case (b_sel)
      B_MDR:   b_bus = regs[C_MDR];
      B_PC:    b_bus = regs[C_PC];
      B_MBR_S: b_bus = sext8(mbr);
      B_MBR_U: b_bus = {{(WORD_W-8){1'b0}}, mbr};
      B_SP:    b_bus = regs[C_SP];
      B_LV:    b_bus = regs[C_LV];
      B_CPP:   b_bus = regs[C_CPP];
      B_TOS:   b_bus = regs[C_TOS];
      B_OPC:   b_bus = regs[C_OPC];
      default: b_bus = '0;
    endcase
  end

  // A bus and memory addresses follow the registers directly; MAR is a word index
  always_comb begin
    a_bus         = regs[C_H];
    mem.mem_addr  = regs[C_MAR] << 2;
    mem.mem_wdata = regs[C_MDR];
    mem.ifu_addr  = regs[C_PC];
  end

endmodule
`default_nettype wire

// File: tb/tb_mic1_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_mic1_reg_file
// Description : Self-checking bench for mic1_reg_file: directed scenarios
//               plus randomized microinstructions against a register-level
//               reference model with a variable-latency memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mic1_reg_file;
  import mic1_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  b_sel;
  logic [8:0]  c_en;
  logic [31:0] c_bus;
  logic        rd, wr, fetch;
  logic [31:0] a_bus, b_bus;
  logic        stall;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mic1_reg_file_if mif ();

  mic1_reg_file #(
    .PC_RST  (32'h0000_0000),
    .SP_RST  (32'h0000_8000),
    .LV_RST  (32'h0000_8000),
    .CPP_RST (32'h0000_4000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .b_sel (b_sel),
    .c_en  (c_en),
    .c_bus (c_bus),
    .rd    (rd),
    .wr    (wr),
    .fetch (fetch),
    .a_bus (a_bus),
    .b_bus (b_bus),
    .stall (stall),
    .mem   (mif)
  );

  task automatic set_ui(input logic [3:0] bs, input logic [8:0] ce, input logic [31:0] cb,
                        input logic r, input logic w, input logic f);
    b_sel = bs; c_en = ce; c_bus = cb; rd = r; wr = w; fetch = f;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_ui(4'd4, 9'h000, 32'h0, 1'b0, 1'b0, 1'b0);
    mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;
    mif.ifu_rvalid = 1'b0; mif.ifu_rdata = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (b_bus !== 32'h0000_8000) begin bad++; $display("FAIL reset_sp b_bus=%h expected=%h", b_bus, 32'h8000); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall stall=%b expected=0", stall); end
    total++; if ({mif.mem_rd_req, mif.mem_wr_req, mif.ifu_req} !== 3'b000) begin bad++; $display("FAIL reset_req reqs=%b expected=000", {mif.mem_rd_req, mif.mem_wr_req, mif.ifu_req}); end
    total++; if (a_bus !== 32'h0) begin bad++; $display("FAIL reset_h a_bus=%h expected=0", a_bus); end
    b_sel = 4'd1; #1;
    total++; if (b_bus !== 32'h0) begin bad++; $display("FAIL reset_pc b_bus=%h expected=0", b_bus); end
    b_sel = 4'd6; #1;
    total++; if (b_bus !== 32'h0000_4000) begin bad++; $display("FAIL reset_cpp b_bus=%h expected=%h", b_bus, 32'h4000); end
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_write_readback();
    set_ui(4'd9, 9'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    next_cycle();
    set_ui(4'd9, 9'h000, 32'h0, 1'b0, 1'b0, 1'b0);
    #3;
    total++; if (a_bus !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wb_h a_bus=%h expected=%h", a_bus, 32'hDEAD_BEEF); end
    total++; if (b_bus !== 32'h0) begin bad++; $display("FAIL wb_sel9 b_bus=%h expected=0", b_bus); end
    next_cycle();
  endtask

  task automatic test_read_hazard();
    set_ui(4'd9, 9'h001, 32'd5, 1'b1, 1'b0, 1'b0);
    #3;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rdh_first_stall stall=%b expected=0", stall); end
    next_cycle();
    set_ui(4'd0, 9'h000, 32'h0, 1'b0, 1'b0, 1'b0);
    #3;
    total++; if (mif.mem_rd_req !== 1'b1) begin bad++; $display("FAIL rdh_req mem_rd_req=%b expected=1", mif.mem_rd_req); end
    total++; if (mif.mem_addr !== 32'h14) begin bad++; $display("FAIL rdh_addr mem_addr=%h expected=14", mif.mem_addr); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rdh_stall_issue stall=%b expected=1", stall); end
    next_cycle();
    #3;
    total++; if (mif.mem_rd_req !== 1'b0) begin bad++; $display("FAIL rdh_pulse mem_rd_req=%b expected=0", mif.mem_rd_req); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rdh_stall_pend stall=%b expected=1", stall); end
    next_cycle();
    mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h1234;
    #3;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rdh_stall_rvalid stall=%b expected=1", stall); end
    next_cycle();
    mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;
    #3;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rdh_release stall=%b expected=0", stall); end
    total++; if (b_bus !== 32'h1234) begin bad++; $display("FAIL rdh_data b_bus=%h expected=1234", b_bus); end
    next_cycle();
  endtask

  task automatic test_fetch_sign();
    set_ui(4'd9, 9'h004, 32'd3, 1'b0, 1'b0, 1'b1);
    next_cycle();
    set_ui(4'd9, 9'h000, 32'h0, 1'b0, 1'b0, 1'b0);
    #3;
    total++; if (mif.ifu_req !== 1'b1) begin bad++; $display("FAIL ft_req ifu_req=%b expected=1", mif.ifu_req); end
    total++; if (mif.ifu_addr !== 32'd3) begin bad++; $display("FAIL ft_addr ifu_addr=%h expected=3", mif.ifu_addr); end
    next_cycle();
    mif.ifu_rvalid = 1'b1; mif.ifu_rdata = 8'h9C; b_sel = 4'd2;
    #3;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL ft_stall stall=%b expected=1", stall); end
    next_cycle();
    mif.ifu_rvalid = 1'b0; mif.ifu_rdata = 8'h00;
    #3;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL ft_release stall=%b expected=0", stall); end
    total++; if (b_bus !== 32'hFFFF_FF9C) begin bad++; $display("FAIL ft_sext b_bus=%h expected=FFFFFF9C", b_bus); end
    b_sel = 4'd3; #1;
    total++; if (b_bus !== 32'h0000_009C) begin bad++; $display("FAIL ft_zext b_bus=%h expected=0000009C", b_bus); end
    next_cycle();
  endtask

  task automatic test_write();
    set_ui(4'd9, 9'h002, 32'd7, 1'b0, 1'b0, 1'b0);
    next_cycle();
    set_ui(4'd9, 9'h001, 32'd2, 1'b0, 1'b1, 1'b0);
    next_cycle();
    set_ui(4'd9, 9'h000, 32'h0, 1'b0, 1'b0, 1'b0);
    #3;
    total++; if (mif.mem_wr_req !== 1'b1) begin bad++; $display("FAIL wr_req mem_wr_req=%b expected=1", mif.mem_wr_req); end
    total++; if (mif.mem_addr !== 32'h8) begin bad++; $display("FAIL wr_addr mem_addr=%h expected=8", mif.mem_addr); end
    total++; if (mif.mem_wdata !== 32'h7) begin bad++; $display("FAIL wr_data mem_wdata=%h expected=7", mif.mem_wdata); end
    total++; if (stall !== 1'b0 || mif.mem_rd_req !== 1'b0) begin bad++; $display("FAIL wr_nostall stall=%b rd_req=%b expected=0/0", stall, mif.mem_rd_req); end
    next_cycle();
    #3;
    total++; if (mif.mem_wr_req !== 1'b0) begin bad++; $display("FAIL wr_pulse mem_wr_req=%b expected=0", mif.mem_wr_req); end
    next_cycle();
  endtask

  task automatic test_mid_read_reset();
    set_ui(4'd9, 9'h001, 32'd1, 1'b1, 1'b0, 1'b0);
    next_cycle();
    set_ui(4'd9, 9'h000, 32'h0, 1'b0, 1'b0, 1'b0);
    #3;
    total++; if (mif.mem_rd_req !== 1'b1) begin bad++; $display("FAIL mrr_req mem_rd_req=%b expected=1", mif.mem_rd_req); end
    next_cycle();
    b_sel = 4'd0;
    #3;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mrr_pend stall=%b expected=1", stall); end
    rst_n = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mrr_rst_stall stall=%b expected=0", stall); end
    total++; if (b_bus !== 32'h0) begin bad++; $display("FAIL mrr_rst_mdr b_bus=%h expected=0", b_bus); end
    rst_n = 1'b1;
    next_cycle();
    mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'hAAAA_5555;
    next_cycle();
    mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;
    #3;
    total++; if (b_bus !== 32'h0) begin bad++; $display("FAIL mrr_late_rvalid b_bus=%h expected=0", b_bus); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mrr_after stall=%b expected=0", stall); end
    next_cycle();
  endtask

  // Randomized microinstructions vs. a register-level model of the stage
  task automatic test_random();
    logic [31:0] m [9];
    logic [7:0]  m_mbr;
    bit          m_rd_out, m_ft_out;
    int          rd_cnt, ft_cnt;
    bit          exp_rd_req, exp_wr_req, exp_ifu_req;
    bit          held, acc, real_rv, real_fv;
    bit          exp_stall;
    logic [31:0] exp_b;

    rst_n = 1'b0;
    set_ui(4'd9, 9'h000, 32'h0, 1'b0, 1'b0, 1'b0);
    mif.mem_rvalid = 1'b0; mif.ifu_rvalid = 1'b0;
    #2;
    rst_n = 1'b1;
    next_cycle();
    for (int i = 0; i < 9; i++) m[i] = 32'h0;
    m[C_PC] = 32'h0; m[C_SP] = 32'h8000; m[C_LV] = 32'h8000; m[C_CPP] = 32'h4000;
    m_mbr = 8'h00;
    m_rd_out = 0; m_ft_out = 0; rd_cnt = 0; ft_cnt = 0;
    exp_rd_req = 0; exp_wr_req = 0; exp_ifu_req = 0; held = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!held) begin
        b_sel = 4'($urandom_range(0, 15));
        c_en  = 9'($urandom) & 9'($urandom);
        c_bus = $urandom;
        rd    = ($urandom_range(0, 3) == 0);
        wr    = ($urandom_range(0, 5) == 0);
        fetch = ($urandom_range(0, 3) == 0);
      end
      mif.mem_rvalid = 1'b0; mif.mem_rdata = $urandom;
      mif.ifu_rvalid = 1'b0; mif.ifu_rdata = 8'($urandom);
      real_rv = 0; real_fv = 0;
      if (m_rd_out && !exp_rd_req) begin
        if (rd_cnt == 0) begin mif.mem_rvalid = 1'b1; real_rv = 1; end
        else rd_cnt--;
      end else if (!m_rd_out && $urandom_range(0, 9) == 0) begin
        mif.mem_rvalid = 1'b1;
      end
      if (m_ft_out && !exp_ifu_req) begin
        if (ft_cnt == 0) begin mif.ifu_rvalid = 1'b1; real_fv = 1; end
        else ft_cnt--;
      end else if (!m_ft_out && $urandom_range(0, 9) == 0) begin
        mif.ifu_rvalid = 1'b1;
      end
      #3;
      exp_stall = (m_rd_out && (rd || b_sel == 4'd0 || c_en[C_MDR])) ||
                  (m_ft_out && (fetch || b_sel == 4'd2 || b_sel == 4'd3));
      case (b_sel)
        4'd0: exp_b = m[C_MDR];
        4'd1: exp_b = m[C_PC];
        4'd2: exp_b = 32'($signed(m_mbr));
        4'd3: exp_b = 32'(m_mbr);
        4'd4: exp_b = m[C_SP];
        4'd5: exp_b = m[C_LV];
        4'd6: exp_b = m[C_CPP];
        4'd7: exp_b = m[C_TOS];
        4'd8: exp_b = m[C_OPC];
        default: exp_b = 32'h0;
      endcase
      total++; if (stall !== exp_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d stall=%b expected=%b", cyc, stall, exp_stall); end
      total++; if (b_bus !== exp_b) begin bad++; $display("FAIL rnd_b cyc=%0d sel=%0d b_bus=%h expected=%h", cyc, b_sel, b_bus, exp_b); end
      total++; if (a_bus !== m[C_H]) begin bad++; $display("FAIL rnd_a cyc=%0d a_bus=%h expected=%h", cyc, a_bus, m[C_H]); end
      total++; if ({mif.mem_rd_req, mif.mem_wr_req, mif.ifu_req} !== {exp_rd_req, exp_wr_req, exp_ifu_req}) begin
        bad++; $display("FAIL rnd_req cyc=%0d reqs=%b expected=%b", cyc, {mif.mem_rd_req, mif.mem_wr_req, mif.ifu_req}, {exp_rd_req, exp_wr_req, exp_ifu_req});
      end
      if (exp_rd_req || exp_wr_req) begin
        total++; if (mif.mem_addr !== m[C_MAR] * 4) begin bad++; $display("FAIL rnd_addr cyc=%0d mem_addr=%h expected=%h", cyc, mif.mem_addr, m[C_MAR] * 4); end
      end
      if (exp_wr_req) begin
        total++; if (mif.mem_wdata !== m[C_MDR]) begin bad++; $display("FAIL rnd_wdata cyc=%0d mem_wdata=%h expected=%h", cyc, mif.mem_wdata, m[C_MDR]); end
      end
      if (exp_ifu_req) begin
        total++; if (mif.ifu_addr !== m[C_PC]) begin bad++; $display("FAIL rnd_iaddr cyc=%0d ifu_addr=%h expected=%h", cyc, mif.ifu_addr, m[C_PC]); end
      end
      @(posedge clk);
      acc = !exp_stall;
      if (acc) begin
        for (int i = 0; i < 9; i++) if (c_en[i]) m[i] = c_bus;
      end
      if (real_rv) begin m[C_MDR] = mif.mem_rdata; m_rd_out = 0; end
      if (real_fv) begin m_mbr = mif.ifu_rdata; m_ft_out = 0; end
      exp_rd_req  = acc && rd;
      exp_wr_req  = acc && wr;
      exp_ifu_req = acc && fetch;
      if (exp_rd_req)  begin m_rd_out = 1; rd_cnt = $urandom_range(0, 2); end
      if (exp_ifu_req) begin m_ft_out = 1; ft_cnt = $urandom_range(0, 2); end
      held = exp_stall;
      #1;
    end
    mif.mem_rvalid = 1'b0; mif.ifu_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_read_hazard();
    test_fetch_sign();
    test_write();
    test_mid_read_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
